// File: rtl/fpu_pkg.sv
// Shared types for the fp adder scheduler: FSM state encoding and word width.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fpu_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/fadd_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    logic found;

    // Walk ptr, ptr+1, ... (mod N) and grant the first requester seen.
    always_comb begin
        int cand;
        cand    = 0;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fadd_sched.sv
// Shares one fp32 adder among NREQ requesters, one operation in flight, round-robin grant.
// Latency: handshake edge T -> result presented to owner after edge T+ADD_LAT; new grant every ADD_LAT+2 cycles at best.
// Backpressure: result held in RESP until the owner's resp_ready; no new grants until it is taken.
module fadd_sched
    import fpu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [FP_W-1:0]      add_a,
    output logic [FP_W-1:0]      add_b,
    input  logic [FP_W-1:0]      add_res,
    output logic [NREQ-1:0]      resp_valid,
    output logic [FP_W-1:0]      resp_res,
    input  logic [NREQ-1:0]      resp_ready,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(ADD_LAT + 1);

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   cnt;
    logic [FP_W-1:0] op_a;
    logic [FP_W-1:0] op_b;
    logic [FP_W-1:0] res_q;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   ptr_next;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Pointer moves just past the winner so it becomes lowest priority next round.
    assign ptr_next = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, count down the adder latency in BUSY, wait for the owner in RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_valid) state_d = BUSY;
            BUSY:    if (cnt == CW'(1)) state_d = RESP;
            RESP:    if (resp_ready[owner]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the granted operands, owner and pointer on handshake; latch the sum on the last BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            owner  <= '0;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            res_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        op_a   <= req_a[int'(gnt_idx) * FP_W +: FP_W];
                        op_b   <= req_b[int'(gnt_idx) * FP_W +: FP_W];
                        owner  <= gnt_idx;
                        rr_ptr <= ptr_next;
                        cnt    <= CW'(ADD_LAT);
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        res_q <= add_res;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: grant only while idle and out of reset; result routed to the owner only in RESP.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (state_q == IDLE && !rst) begin
            req_ready = gnt;
        end
        if (state_q == RESP) begin
            resp_valid[owner] = 1'b1;
        end
    end

    // Operand registers feed the adder directly, so they hold their last value between ops.
    assign add_a    = op_a;
    assign add_b    = op_b;
    assign resp_res = res_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fadd_sched.sv
// Bench for fadd_sched: requester queues drive operands, a scoreboard holds hand-computed sums,
// a negedge monitor pops and compares on every response handshake.
// Directed tests: reset, single op latency, cancellation, idle pointer hold, wrap, backpressure, fairness, mid-op reset.
module tb_fadd_sched;

    localparam int NREQ    = 4;
    localparam int ADD_LAT = 2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        chk;
    } op_t;

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] res;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [31:0]          add_a;
    logic [31:0]          add_b;
    logic [31:0]          add_res;
    logic [NREQ-1:0]      resp_valid;
    logic [31:0]          resp_res;
    logic [NREQ-1:0]      resp_ready;
    logic                 busy;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    op_t  ops [NREQ][16];
    int   head [NREQ];
    int   tail [NREQ];
    exp_t sb [$];
    int   gl_idx [$];
    int   gl_edge [$];

    fadd_sched #(
        .NREQ    (NREQ),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_res    (add_res),
        .resp_valid (resp_valid),
        .resp_res   (resp_res),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // fp32 <-> real for normal numbers and zero, enough for the directed vectors.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'h0;
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    // Adder model: operands launched at edge T are summed into one register at T+1,
    // so the sum is settled when the scheduler samples it at edge T+ADD_LAT (=2).
    always @(posedge clk) add_res <= r2f(f2r(add_a) + f2r(add_b));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every response handshake must match the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (resp_valid & resp_ready) != '0) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("resp_owner", 64'(resp_valid), 64'(4'b0001 << e.who));
                check("resp_res", 64'(resp_res), 64'(e.res));
            end
        end
    end

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]       = 1'b1;
                req_a[32*i +: 32]  = ops[i][head[i]].a;
                req_b[32*i +: 32]  = ops[i][head[i]].b;
            end else begin
                req_valid[i]       = 1'b0;
            end
        end
    endtask

    task automatic enq(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sum, input logic chk);
        op_t o;
        o.a   = a;
        o.b   = b;
        o.sum = sum;
        o.chk = chk;
        ops[i][tail[i]] = o;
        tail[i]++;
        refresh();
    endtask

    // One clock: note handshakes before the edge, then advance requesters just after it.
    task automatic tick();
        logic [NREQ-1:0] hs;
        exp_t e;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                if (ops[i][head[i]].chk) begin
                    e.who = 2'(i);
                    e.res = ops[i][head[i]].sum;
                    sb.push_back(e);
                end
                gl_idx.push_back(i);
                gl_edge.push_back(cyc);
                head[i]++;
            end
        end
        refresh();
    endtask

    function automatic logic all_idle();
        logic r;
        r = (sb.size() == 0) && !busy;
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] != tail[i]) r = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_grants(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (gl_idx.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, 64'(gl_idx.size() >= n), 64'd1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (!all_idle() && k < 200) begin
            tick();
            k++;
        end
        check(name, 64'(all_idle()), 64'd1);
    endtask

    task automatic clear_log();
        gl_idx.delete();
        gl_edge.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_req_ready"},  64'(req_ready),  64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_add_a"},      64'(add_a),      64'd0);
        check({tag, "_add_b"},      64'(add_b),      64'd0);
        check({tag, "_resp_res"},   64'(resp_res),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int k;
        logic seen;

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '1;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end

        // Reset state.
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single op on req0: 1.0 + 2.0 = 3.0, response two edges after the handshake edge.
        clear_log();
        enq(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1);
        wait_grants(1, 20, "single_grant");
        t0 = gl_edge[0];
        check("single_idx",   64'(gl_idx[0]), 64'd0);
        check("single_busy",  64'(busy),      64'd1);
        check("single_add_a", 64'(add_a),     64'h3F800000);
        check("single_add_b", 64'(add_b),     64'h40000000);
        check("single_rdy0",  64'(req_ready), 64'd0);
        k = 0;
        while (!resp_valid[0] && k < 20) begin
            tick();
            k++;
        end
        check("single_latency", 64'(cyc - t0), 64'(ADD_LAT));
        drain("single_drain");

        // Cancellation on req1: 3.0 + -3.0 = +0.
        enq(1, 32'h40400000, 32'hC0400000, 32'h00000000, 1'b1);
        drain("cancel_drain");

        // Idle with nothing valid must not move the pointer (it sits at 2): {0,2} -> 2 then 0.
        for (int i = 0; i < 6; i++) tick();
        clear_log();
        enq(0, 32'h3F800000, 32'h3F000000, 32'h3FC00000, 1'b1);
        enq(2, 32'h40000000, 32'h40000000, 32'h40800000, 1'b1);
        wait_grants(2, 40, "idle_grants");
        check("idle_first",  64'(gl_idx[0]), 64'd2);
        check("idle_second", 64'(gl_idx[1]), 64'd0);
        drain("idle_drain");

        // Wrap: req2 alone puts the pointer at 3, then {1,3} -> 3 then 1.
        enq(2, 32'h41000000, 32'h41000000, 32'h41800000, 1'b1);
        drain("wrap_pre_drain");
        clear_log();
        enq(1, 32'hC0000000, 32'hBF800000, 32'hC0400000, 1'b1);
        enq(3, 32'h40800000, 32'hBF800000, 32'h40400000, 1'b1);
        wait_grants(2, 40, "wrap_grants");
        check("wrap_first",  64'(gl_idx[0]), 64'd3);
        check("wrap_second", 64'(gl_idx[1]), 64'd1);
        drain("wrap_drain");

        // Backpressure: req2 withholds resp_ready for 10 cycles while req0 waits.
        resp_ready[2] = 1'b0;
        clear_log();
        enq(2, 32'h40000000, 32'h3F000000, 32'h40200000, 1'b1);
        wait_grants(1, 20, "bp_grant");
        k = 0;
        while (!resp_valid[2] && k < 20) begin
            tick();
            k++;
        end
        enq(0, 32'h3F000000, 32'h3E800000, 32'h3F400000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("bp_resp_valid", 64'(resp_valid), 64'h4);
            check("bp_resp_res",   64'(resp_res),   64'h40200000);
            check("bp_req_ready",  64'(req_ready),  64'd0);
            check("bp_busy",       64'(busy),       64'd1);
            tick();
        end
        resp_ready[2] = 1'b1;
        drain("bp_drain");

        // Fairness from a fresh pointer: all four valid continuously -> 0,1,2,3,0, four cycles apart.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_log();
        enq(0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1);
        enq(1, 32'h3F800000, 32'hBF000000, 32'h3F000000, 1'b1);
        enq(2, 32'h3F000000, 32'h3E800000, 32'h3F400000, 1'b1);
        enq(3, 32'h41000000, 32'h41000000, 32'h41800000, 1'b1);
        enq(0, 32'h40000000, 32'h40000000, 32'h40800000, 1'b1);
        enq(1, 32'h40000000, 32'h3F000000, 32'h40200000, 1'b1);
        enq(2, 32'hC0000000, 32'hBF800000, 32'hC0400000, 1'b1);
        enq(3, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1);
        wait_grants(5, 60, "rr_grants");
        for (int i = 0; i < 5; i++) begin
            check("rr_order", 64'(gl_idx[i]), 64'(i % NREQ));
        end
        for (int i = 1; i < 5; i++) begin
            check("rr_spacing", 64'(gl_edge[i] - gl_edge[i-1]), 64'(ADD_LAT + 2));
        end
        drain("rr_drain");

        // Reset while BUSY: outputs return to reset values and the op never responds.
        clear_log();
        enq(3, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0);
        wait_grants(1, 20, "mid_grant");
        tick();
        check("mid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resp_valid != '0) seen = 1'b1;
        end
        check("mid_no_resp", 64'(seen), 64'd0);
        check("mid_idle",    64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
